// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the instruction-cache refill path.
//   refill_state_e : refill controller states
//   LINE_W         : cache line width in bits
//   LINE_OFF_BITS  : byte-offset bits within a line
//   line_addr()    : clears the offset bits of a byte address
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int LINE_W        = 64;
  localparam int LINE_OFF_BITS = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    RECV   = 3'd2,
    FILL   = 3'd3,
    SETTLE = 3'd4
  } refill_state_e;

  // Line-aligned address of the line holding byte address a.
  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return a & ~((32'd1 << LINE_OFF_BITS) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// ---------------------------------------------------------------------------
// icache_refill_if
// Bundles the fetch-side and memory-side signals of the refill controller.
//   fetch side : pc, miss (in); stall, fill, stream, miss_count (out)
//   memory side: mem_gnt, mem_rvalid, mem_rdata (in); mem_req, mem_addr (out)
// Modports: master = refill controller, slave = fetch stage + memory bus.
//
// Handshake: mem_req is a request held high, with mem_addr constant, until
// the first cycle mem_gnt=1 (transfer happens on that rising edge); mem_gnt
// has no meaning while mem_req=0. Each cycle with mem_rvalid=1 carries one
// data beat, lowest address first; there is no back-pressure on beats.
// ---------------------------------------------------------------------------
interface icache_refill_if #(
  parameter int MEM_W = 32
);

  logic [31:0]      pc;
  logic             miss;
  logic             stall;
  logic             fill;
  logic [63:0]      stream;
  logic [15:0]      miss_count;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [MEM_W-1:0] mem_rdata;

  modport master (
    input  pc, miss, mem_gnt, mem_rvalid, mem_rdata,
    output stall, fill, stream, miss_count, mem_req, mem_addr
  );

  modport slave (
    output pc, miss, mem_gnt, mem_rvalid, mem_rdata,
    input  stall, fill, stream, miss_count, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
// Miss-service controller between the instruction cache and the memory bus.
// On a miss it stalls the PC, reads the 64-bit line holding the PC in
// MEM_W-bit beats, presents the assembled line on stream with a one-cycle
// fill strobe, then waits one settle cycle before releasing the stall.
//   clk         : clock, rising edge
//   reset       : synchronous, active-high
//   bus         : icache_refill_if.master (fetch + memory signals)
//   o_dbg_state : current controller state
// ---------------------------------------------------------------------------
module icache_refill
  import mips_pkg::*;
#(
  parameter int MEM_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  icache_refill_if.master bus,
  output refill_state_e   o_dbg_state
);

  localparam int BEATS = LINE_W / MEM_W;
  localparam int CNT_W = $clog2(BEATS) + 1;

  refill_state_e    r_state;
  refill_state_e    w_next;
  logic [CNT_W-1:0] r_beat;
  logic [CNT_W-1:0] w_beat_inc;
  logic [LINE_W-1:0] r_stream;
  logic [31:0]      r_addr;
  logic [15:0]      r_miss_count;
  logic             w_start;
  logic             w_beat_ok;
  logic             w_last_beat;

  assign w_start     = (r_state == IDLE) && bus.miss;
  // Beats outside RECV are stray and must not touch the line.
  assign w_beat_ok   = (r_state == RECV) && bus.mem_rvalid;
  assign w_beat_inc  = r_beat + CNT_W'(1);
  assign w_last_beat = w_beat_ok && (w_beat_inc == CNT_W'(BEATS));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.miss) w_next = REQ;
      REQ:     if (bus.mem_gnt) w_next = RECV;
      RECV:    if (w_last_beat) w_next = FILL;
      FILL:    w_next = SETTLE;
      // Tags are being written this cycle, so miss is not trustworthy.
      SETTLE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: line address, beat counter, line assembly, refill counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_miss_count <= '0;
      r_beat       <= '0;
      r_stream     <= '0;
    end else begin
      if (w_start) begin
        r_addr       <= line_addr(bus.pc);
        r_miss_count <= r_miss_count + 16'd1;
      end
      if ((r_state == REQ) && bus.mem_gnt) begin
        r_beat <= '0;
      end else if (w_beat_ok) begin
        r_beat <= w_beat_inc;
      end
      if (w_beat_ok) begin
        for (int k = 0; k < BEATS; k++) begin
          if (r_beat == CNT_W'(k)) begin
            r_stream[k*MEM_W +: MEM_W] <= bus.mem_rdata;
          end
        end
      end
    end
  end

  // stall must rise in the very cycle the miss is seen so the PC holds.
  assign bus.stall      = (r_state != IDLE) || bus.miss;
  assign bus.fill       = (r_state == FILL);
  assign bus.mem_req    = (r_state == REQ);
  assign bus.mem_addr   = r_addr;
  assign bus.stream     = r_stream;
  assign bus.miss_count = r_miss_count;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-service controller between the instruction cache and the memory bus. When the fetch stage reports a miss, it stalls the PC and reads the 64-bit line containing the PC from memory in `MEM_W`-bit beats. It assembles the line and presents it on `fill`/`stream` for exactly one cycle, then waits one settle cycle before releasing the stall.

## Interface
- `MEM_W`, 32: memory data width; must be 32 or 64; `BEATS = 64/MEM_W`.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: current fetch PC; stable while `stall`=1.
- `miss` in 1: tag miss for `pc` (combinational from tags).
- `stall` out 1: hold PC; hazard logic forces `pc_write`=0 while high.
- `fill` out 1: one-cycle cache/tag write strobe.
- `stream` out 64: assembled line, valid when `fill`=1.
- `mem_req` out 1: read request; held until granted.
- `mem_addr` out 32: line address `{pc[31:3],3'b000}`, stable while `mem_req`=1.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: one data beat valid.
- `mem_rdata` in MEM_W: beat data.
- `miss_count` out 16: refills started since reset; wraps at 0xFFFF→0.

## Operation
- States:
  - IDLE: `miss`=1 → REQ; latch line address; `miss_count`+1.
  - REQ: `mem_req`=1; `mem_gnt`=1 → RECV; beat counter cleared.
  - RECV: each `mem_rvalid` stores `mem_rdata` into `stream[k*MEM_W +: MEM_W]` (k = beat index, beat 0 = lowest address) and increments k. Last beat → FILL.
  - FILL: `fill`=1 for this cycle only → SETTLE.
  - SETTLE: `miss` ignored while tags update → IDLE.
- `stall` = (state≠IDLE) | (state==IDLE & `miss`). It is combinational so the PC never advances on a missing fetch.
- `mem_rvalid` is ignored outside RECV. `mem_gnt` is ignored outside REQ.
- The beat counter is `$clog2(BEATS)+1` bits and is compared to BEATS; no wrap.
- `stream` holds its last value outside FILL; consumers use it only under `fill`.
- A branch during refill has no effect here: the PC is frozen, and the line is always completed and written. It is valid cache content.
- `miss` in IDLE the cycle after SETTLE starts a new refill (back-to-back misses across a line boundary).
- Reset values: state=IDLE, `stall`=0 (if `miss`=0), `fill`=0, `mem_req`=0, `mem_addr`=0, `stream`=0, `miss_count`=0, beat counter=0.
- Reset mid-refill forces IDLE next cycle and drops `mem_req` with no fill. The memory side is reset by the same `reset`, so no stale beats arrive.

## Timing
- Cycle 0: `miss`=1 in IDLE → `stall`=1 same cycle.
- Cycle 1: `mem_req`=1 (registered).
- Cycle g: first cycle with `mem_gnt`=1 while in REQ.
- Beats are accepted from cycle g+1 onward. After the last beat at cycle b, `fill`=1 at cycle b+1 and SETTLE at b+2.
- IDLE at b+3; `stall` is low at b+3 if `miss`=0.
- Minimum miss penalty for MEM_W=32 with zero-wait memory: gnt at 1, beats at 2–3, fill at 4, stall released at 6.
- `mem_addr`/`mem_req` change only on clock edges; no combinational path from `mem_gnt` to `mem_req`.

## Structure
- Shared package `mips_pkg`:
  - Refill state enum (IDLE, REQ, RECV, FILL, SETTLE).
  - `LINE_W`=64.
  - `LINE_OFF_BITS`=3.
  - Line-address helper.
- Single module; no sub-module required.
- Optional sub-module `line_assembler` (beat counter + shift/insert register). Use it if the team wants to reuse it for a future dcache refill.

## Test plan
- Zero-wait refill, MEM_W=32, pc=0x0000_0104, `miss`=1, gnt at cycle 1, rdata 0x11111111 then 0x22222222 → `mem_addr`=0x0000_0100, `fill`=1 at cycle 4 only, `stream`=0x22222222_11111111, `stall` low at cycle 6, `miss_count`=1.
- Grant held off 5 cycles and one idle gap between beats → `mem_req` held with a constant `mem_addr` until gnt; `fill` exactly one cycle after the second beat.
- Spurious `mem_rvalid` in IDLE and REQ → ignored; `stream` unchanged; no fill.
- `reset` asserted after the first beat → next cycle IDLE, `mem_req`=0, `fill` never pulses, `miss_count`=0.
- Back-to-back misses at pc 0x100 then 0x108 → two complete refills, second `mem_addr`=0x108, `miss_count`=2, `miss` during SETTLE ignored.
- MEM_W=64, single beat 0xDEADBEEF_CAFEF00D → fill 2 cycles after gnt with identical `stream`; counter wrap: 65536 refills → `miss_count`=0.
